// File: rtl/freq_meter_pkg.sv
// Shared state encoding and counter-limit helper for the freq_meter block.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArm     = 2'd1,
      StMeasure = 2'd2,
      StReport  = 2'd3
   } state_e;

   // All-ones value for a counter of the given width (saturation point).
   function automatic logic [63:0] cnt_max(input int unsigned width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/freq_meter_edge.sv
// Rise/fall detector for freq_in; define FREQ_METER_SYNC_EN to insert a
// 2-flop synchroniser ahead of the detector for asynchronous sources.
module freq_meter_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic freq_in,
   output logic rise,
   output logic fall
);

   logic fin;
   logic fin_q;

`ifdef FREQ_METER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], freq_in};
      end
   end

   assign fin = sync_q[1];
`else
   assign fin = freq_in;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fin_q <= 1'b0;
      end else begin
         fin_q <= fin;
      end
   end

   assign rise = fin & ~fin_q;
   assign fall = ~fin & fin_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of freq_in in clk cycles and returns them over
// valid/ready. FREQ_METER_SYNC_EN (see freq_meter_edge) adds input synchronisation.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned CONTINUOUS = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             freq_in,
   input  logic             start,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             overflow,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             hi_seen_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_q;
   logic             overflow_q;
   logic             rise;
   logic             fall;

   freq_meter_edge u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .freq_in (freq_in),
      .rise    (rise),
      .fall    (fall)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      meas_valid = 1'b0;
      busy       = 1'b1;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) state_d = StArm;
         end
         StArm: begin
            if (rise) state_d = StMeasure;
         end
         StMeasure: begin
            if (rise) state_d = StReport;
         end
         StReport: begin
            meas_valid = 1'b1;
            if (meas_ready) state_d = (CONTINUOUS != 0) ? StArm : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         hi_seen_q  <= 1'b0;
         period_q   <= '0;
         high_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         unique case (state_q)
            StArm: begin
               if (rise) begin
                  cnt_q     <= CNT_W'(1);
                  ovf_q     <= 1'b0;
                  hi_seen_q <= 1'b0;
               end
            end
            StMeasure: begin
               if (cnt_q == CntMax) begin
                  ovf_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               if (fall && !hi_seen_q) begin
                  high_q    <= cnt_q;
                  hi_seen_q <= 1'b1;
               end
               // A rise with no fall seen yet means the high phase filled the period.
               if (rise) begin
                  period_q   <= cnt_q;
                  overflow_q <= ovf_q;
                  if (!hi_seen_q) high_q <= cnt_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomised self-checking bench for freq_meter: a wide continuous instance and a
// 4-bit single-shot instance see the same generated divide-by-N waveform.
`timescale 1ns/1ps
module tb_freq_meter;

`ifdef FREQ_METER_SYNC_EN
   localparam int Lat = 2;
`else
   localparam int Lat = 0;
`endif
   localparam int SmallMax = 15;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic        freq_in    = 1'b0;
   logic        start      = 1'b0;
   logic        meas_ready = 1'b0;
   logic [15:0] period_a, high_a;
   logic        ovf_a, valid_a, busy_a;
   logic [3:0]  period_b, high_b;
   logic        ovf_b, valid_b, busy_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Waveform generator state: divide-by-gen_n, high for gen_h cycles.
   int gen_n     = 8;
   int gen_h     = 4;
   int gen_phase = 0;
   bit gen_en    = 1'b0;
   int rise_base = 0;

   freq_meter #(.CNT_W(16), .CONTINUOUS(1)) u_dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .freq_in    (freq_in),
      .start      (start),
      .period     (period_a),
      .high_time  (high_a),
      .overflow   (ovf_a),
      .meas_valid (valid_a),
      .meas_ready (meas_ready),
      .busy       (busy_a)
   );

   freq_meter #(.CNT_W(4), .CONTINUOUS(0)) u_dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .freq_in    (freq_in),
      .start      (start),
      .period     (period_b),
      .high_time  (high_b),
      .overflow   (ovf_b),
      .meas_valid (valid_b),
      .meas_ready (meas_ready),
      .busy       (busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (gen_en) begin
         freq_in = (gen_phase < gen_h);
         if (gen_phase == 0) rise_base = cyc;
         gen_phase = (gen_phase + 1) % gen_n;
      end else begin
         freq_in = 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_data_a"}, {period_a, high_a}, 32'd0);
      check_eq({tag, "_flags_a"}, 32'({ovf_a, valid_a, busy_a}), 32'd0);
      check_eq({tag, "_data_b"}, 32'({period_b, high_b}), 32'd0);
      check_eq({tag, "_flags_b"}, 32'({ovf_b, valid_b, busy_b}), 32'd0);
   endtask

   // Quiet the input long enough to flush any synchroniser, then restart at phase 0.
   task automatic set_wave(input int n, input int h);
      @(negedge clk);
      gen_en = 1'b0;
      repeat (4) @(negedge clk);
      gen_n     = n;
      gen_h     = h;
      gen_phase = 0;
      gen_en    = 1'b1;
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1;
      meas_ready = 1'b1;
      @(posedge clk); #1;
      meas_ready = 1'b0;
   endtask

   task automatic measure(input int n, input int h, input bit inject, input bit fresh,
                          input int hold);
      int s, c, c2, v;
      int exp_pb, exp_hb, exp_ob;
      bit got;
      exp_pb = (n > SmallMax) ? SmallMax : n;
      exp_hb = (h > SmallMax) ? SmallMax : h;
      exp_ob = (n > SmallMax) ? 1 : 0;

      @(posedge clk); #1;
      s     = cyc;
      start = 1'b1;
      // First rise the detector sees once armed, then the one that closes the period.
      c = rise_base;
      while (c + Lat < s + 1) c += n;
      c2  = c + n;
      got = 1'b0;
      v   = 0;
      for (int i = 0; i < 4 * n + 20 && !got; i++) begin
         @(posedge clk); #1;
         start = inject && (cyc == c + Lat + 2);
         @(negedge clk);
         if (valid_b) begin
            got = 1'b1;
            v   = cyc;
         end
      end
      start = 1'b0;
      check_eq("valid_b_seen", 32'(got), 32'd1);
      check_eq("valid_latency", v, c2 + Lat + 1);
      check_eq("period_b", 32'(period_b), exp_pb);
      check_eq("high_b", 32'(high_b), exp_hb);
      check_eq("ovf_b", 32'(ovf_b), exp_ob);
      if (fresh) begin
         check_eq("valid_a", 32'(valid_a), 32'd1);
         check_eq("period_a", 32'(period_a), n);
         check_eq("high_a", 32'(high_a), h);
         check_eq("ovf_a", 32'(ovf_a), 32'd0);
      end

      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_eq("hold_valid_b", 32'(valid_b), 32'd1);
         check_eq("hold_data_b", 32'({ovf_b, period_b, high_b}), 32'({exp_ob[0], 4'(exp_pb), 4'(exp_hb)}));
         if (fresh) check_eq("hold_period_a", 32'(period_a), n);
      end

      pulse_ready();
      @(negedge clk);
      check_eq("accept_valid_b", 32'(valid_b), 32'd0);
      check_eq("accept_busy_b", 32'(busy_b), 32'd0);
      if (fresh) begin
         check_eq("accept_valid_a", 32'(valid_a), 32'd0);
         check_eq("accept_busy_a", 32'(busy_a), 32'd1);
         got = 1'b0;
         for (int i = 0; i < 4 * n + 20 && !got; i++) begin
            @(negedge clk);
            if (valid_a) got = 1'b1;
         end
         check_eq("rearm_valid_a", 32'(got), 32'd1);
         check_eq("rearm_period_a", 32'(period_a), n);
         check_eq("rearm_high_a", 32'(high_a), h);
         pulse_ready();
         @(negedge clk);
         check_eq("idle_b_stays", 32'({valid_b, busy_b}), 32'd0);
      end
   endtask

   initial begin
      int n_tab[7]     = '{8, 5, 20, 6, 2, 16, 15};
      int h_tab[7]     = '{4, 1, 10, 3, 1, 15, 7};
      bit chain_tab[7] = '{0, 0, 0, 1, 0, 0, 0};
      int n, h, hold;
      bit chain;

      #1;
      check_all_zero("reset_init");

      for (int i = 0; i < 14; i++) begin
         if (i < 7) begin
            n     = n_tab[i];
            h     = h_tab[i];
            chain = chain_tab[i];
         end else begin
            n     = 32'($urandom_range(2, 40));
            h     = 32'($urandom_range(1, n - 1));
            chain = 1'b0;
         end
         hold = (i < 4) ? 5 : 32'($urandom_range(0, 5));

         if (!chain) begin
            @(negedge clk);
            #2;
            reset_n = 1'b0;
            #1;
            check_all_zero("reset_async");
            set_wave(n, h);
            @(negedge clk);
            reset_n = 1'b1;
            repeat (2 * n + 6) @(negedge clk);
            check_eq("no_start_a", 32'({valid_a, busy_a}), 32'd0);
            check_eq("no_start_b", 32'({valid_b, busy_b}), 32'd0);
         end else begin
            set_wave(n, h);
            repeat (3) @(negedge clk);
         end

         measure(n, h, (i % 2 == 1) && (n >= 4), !chain, hold);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
